// File: rtl/mem_load_extender_pkg.sv
// Shared types and constants for the multi-cycle load/extend unit.
package mem_load_extender_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  localparam int MEM_OFF_W = 3;

  // A load is legal only when all of its bytes fit in the register width.
  function automatic logic size_legal(input logic [1:0] sz, input int data_w);
    return (8 << sz) <= data_w;
  endfunction

endpackage

// File: rtl/mem_load_extender_width_extender.sv
// Combinational sign/zero extension of the low 8*2^size bits of an assembly word.
module width_extender
  import mem_load_extender_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] assembly,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] extended
);

  logic [3:0] msb;

  // Sign bit per size; sizes wider than the register never reach the output.
  for (genvar gi = 0; gi < 4; gi++) begin : g_msb
    if ((8 << gi) <= DATA_W) begin : g_fit
      assign msb[gi] = assembly[(8 << gi) - 1];
    end else begin : g_wide
      assign msb[gi] = 1'b0;
    end
  end

  always_comb begin
    int  nbits;
    logic fill;
    nbits    = 8 << size;
    fill     = sign_ext & msb[size];
    extended = '0;
    for (int i = 0; i < DATA_W; i++) begin
      extended[i] = (i < nbits) ? assembly[i] : fill;
    end
  end

endmodule

// File: rtl/mem_load_extender.sv
// Fetches 1/2/4/8 bytes one beat at a time, assembles them little-endian and extends to DATA_W.
module mem_load_extender
  import mem_load_extender_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           size,
  input  logic                 sign_ext,
  output logic                 mem_req,
  output logic [MEM_OFF_W-1:0] mem_off,
  input  logic                 mem_ack,
  input  logic [7:0]           mem_rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [DATA_W-1:0]    data_out
);

  state_t                 state_reg;
  logic [MEM_OFF_W-1:0]   k_reg;
  logic [MEM_OFF_W-1:0]   last_k;
  logic [1:0]             size_reg;
  logic                   sign_reg;
  logic [DATA_W-1:0]      asm_reg;
  logic [DATA_W-1:0]      asm_next;
  logic [DATA_W-1:0]      ext_value;

  // The byte arriving with the current ack is merged before extension so the
  // final beat can be registered straight into data_out.
  for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_lane
    assign asm_next[gi*8 +: 8] = (k_reg == MEM_OFF_W'(gi)) ? mem_rdata : asm_reg[gi*8 +: 8];
  end

  assign last_k = MEM_OFF_W'((1 << size_reg) - 1);

  width_extender #(.DATA_W(DATA_W)) u_ext (
    .assembly (asm_next),
    .size     (size_reg),
    .sign_ext (sign_reg),
    .extended (ext_value)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      size_reg  <= SZ_BYTE;
      sign_reg  <= 1'b0;
      asm_reg   <= '0;
      mem_req   <= 1'b0;
      mem_off   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      data_out  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            size_reg <= size;
            sign_reg <= sign_ext;
            k_reg    <= '0;
            mem_off  <= '0;
            asm_reg  <= '0;
            busy     <= 1'b1;
            if (size_legal(size, DATA_W)) begin
              state_reg <= FETCH;
              mem_req   <= 1'b1;
              err       <= 1'b0;
            end else begin
              state_reg <= DONE;
              done      <= 1'b1;
              err       <= 1'b1;
              data_out  <= '0;
            end
          end
        end
        FETCH: begin
          if (mem_ack) begin
            asm_reg <= asm_next;
            if (k_reg == last_k) begin
              state_reg <= DONE;
              mem_req   <= 1'b0;
              mem_off   <= '0;
              done      <= 1'b1;
              data_out  <= ext_value;
            end else begin
              k_reg   <= k_reg + 1'b1;
              mem_off <= k_reg + 1'b1;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          mem_req   <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_load_extender.sv
// Bench for mem_load_extender: directed table, reset/busy corner cases, random loads vs. a model.
module tb_mem_load_extender;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  size = 2'd0;
  logic        sign_ext = 1'b0;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  int          cur_sel = 0;

  logic        req32, req64, busy32, busy64, done32, done64, err32, err64;
  logic [2:0]  off32, off64;
  logic [31:0] dout32;
  logic [63:0] dout64;

  logic        req_s, busy_s, done_s, err_s;
  logic [2:0]  off_s;
  logic [63:0] dout_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_load_extender #(.DATA_W(32)) dut32 (
    .clk(clk), .reset(reset), .start(start && cur_sel == 0), .size(size), .sign_ext(sign_ext),
    .mem_req(req32), .mem_off(off32), .mem_ack(mem_ack && cur_sel == 0), .mem_rdata(mem_rdata),
    .busy(busy32), .done(done32), .err(err32), .data_out(dout32)
  );

  mem_load_extender #(.DATA_W(64)) dut64 (
    .clk(clk), .reset(reset), .start(start && cur_sel == 1), .size(size), .sign_ext(sign_ext),
    .mem_req(req64), .mem_off(off64), .mem_ack(mem_ack && cur_sel == 1), .mem_rdata(mem_rdata),
    .busy(busy64), .done(done64), .err(err64), .data_out(dout64)
  );

  assign req_s  = (cur_sel == 1) ? req64  : req32;
  assign busy_s = (cur_sel == 1) ? busy64 : busy32;
  assign done_s = (cur_sel == 1) ? done64 : done32;
  assign err_s  = (cur_sel == 1) ? err64  : err32;
  assign off_s  = (cur_sel == 1) ? off64  : off32;
  assign dout_s = (cur_sel == 1) ? dout64 : {32'h0, dout32};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: little-endian value of the first N bytes, extended arithmetically to width w.
  function automatic logic [63:0] model(input int w, input int sz, input logic sg,
                                        input logic [63:0] b, output logic e);
    int n;
    longint unsigned val, wmask, nmask;
    n = 1 << sz;
    e = 1'b0;
    if (8 * n > w) begin
      e = 1'b1;
      return 64'h0;
    end
    val = 0;
    for (int i = 0; i < n; i++) val += longint'(b[8*i +: 8]) << (8 * i);
    wmask = (w == 64) ? ~64'h0 : ((64'h1 << w) - 1);
    nmask = (n == 8) ? ~64'h0 : ((64'h1 << (8 * n)) - 1);
    if (8 * n < w && sg && b[8*n-1]) val = val | (wmask & ~nmask);
    return val;
  endfunction

  task automatic run_load(input int s, input logic [1:0] sz, input logic sg, input logic [63:0] b,
                          input int wb, input int wc, input bit poke,
                          input logic [63:0] exp_d, input logic exp_e, input int exp_lat,
                          input string tag);
    int k = 0, waited = 0, cyc = 0, off_bad = 0, req_cyc = 0, exp_req;
    bit seen = 0;
    exp_req = exp_e ? 0 : ((1 << sz) + ((wb < (1 << sz)) ? wc : 0));
    @(negedge clk);
    cur_sel = s; size = sz; sign_ext = sg; start = 1'b1; mem_ack = 1'b0;
    @(negedge clk);
    start = poke;
    size = ~sz;
    cyc = 1;
    while (cyc < 200 && !seen) begin
      if (done_s) begin
        seen = 1;
        mem_ack = 1'($urandom_range(0, 1));
      end else begin
        if (req_s) begin
          req_cyc++;
          if (off_s !== 3'(k)) off_bad++;
          if (k == wb && waited < wc) begin
            mem_ack = 1'b0;
            waited++;
          end else begin
            mem_ack = 1'b1;
            mem_rdata = (k < 8) ? b[8*k +: 8] : 8'h00;
            k++;
          end
        end else begin
          mem_ack = 1'($urandom_range(0, 1));
          mem_rdata = 8'($urandom);
        end
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, "/done_seen"}, 64'(seen), 64'h1);
    $display("load %s sel=%0d size=%0d sign=%0d lat=%0d data=%h err=%0b", tag, s, sz, sg, cyc, dout_s, err_s);
    if (seen) begin
      check({tag, "/latency"}, 64'(cyc), 64'(exp_lat));
      check({tag, "/data"}, dout_s, exp_d);
      check({tag, "/err"}, 64'(err_s), 64'(exp_e));
      check({tag, "/mem_off"}, 64'(off_bad), 64'h0);
      check({tag, "/req_cycles"}, 64'(req_cyc), 64'(exp_req));
      @(negedge clk);
      start = 1'b0;
      mem_ack = 1'b0;
      check({tag, "/done_pulse"}, 64'(done_s), 64'h0);
      check({tag, "/idle"}, 64'(busy_s), 64'h0);
    end
    start = 1'b0;
    mem_ack = 1'b0;
  endtask

  typedef struct {
    int          sel;
    logic [1:0]  sz;
    logic        sg;
    logic [63:0] bytes;
    int          wb;
    int          wc;
    bit          poke;
    logic [63:0] exp_d;
    logic        exp_e;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{0, 2'd0, 1'b1, 64'h80,               0, 0, 1'b0, 64'hFFFF_FF80,           1'b0, 2};
    vecs[1] = '{0, 2'd1, 1'b0, 64'hF234,             0, 0, 1'b0, 64'h0000_F234,           1'b0, 3};
    vecs[2] = '{0, 2'd1, 1'b1, 64'hF234,             0, 0, 1'b0, 64'hFFFF_F234,           1'b0, 3};
    vecs[3] = '{0, 2'd2, 1'b0, 64'h1234_5678,        2, 2, 1'b0, 64'h1234_5678,           1'b0, 7};
    vecs[4] = '{0, 2'd3, 1'b1, 64'hFFEE_DDCC_BBAA_9988, 0, 0, 1'b0, 64'h0,               1'b1, 1};
    vecs[5] = '{0, 2'd0, 1'b1, 64'h7F,               0, 0, 1'b0, 64'h0000_007F,           1'b0, 2};
    vecs[6] = '{1, 2'd3, 1'b1, 64'h0807_0605_0403_0201, 0, 0, 1'b1, 64'h0807_0605_0403_0201, 1'b0, 9};
    vecs[7] = '{1, 2'd2, 1'b1, 64'h8000_0000,        1, 3, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0, 8};
    vecs[8] = '{1, 2'd0, 1'b0, 64'hFF,               0, 0, 1'b0, 64'h0000_00FF,           1'b0, 2};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      cur_sel = s;
      #1;
      check($sformatf("reset%0d/mem_req", s), 64'(req_s), 64'h0);
      check($sformatf("reset%0d/mem_off", s), 64'(off_s), 64'h0);
      check($sformatf("reset%0d/busy", s), 64'(busy_s), 64'h0);
      check($sformatf("reset%0d/done", s), 64'(done_s), 64'h0);
      check($sformatf("reset%0d/err", s), 64'(err_s), 64'h0);
      check($sformatf("reset%0d/data_out", s), dout_s, 64'h0);
    end

    for (int i = 0; i < 9; i++) begin
      run_load(vecs[i].sel, vecs[i].sz, vecs[i].sg, vecs[i].bytes, vecs[i].wb, vecs[i].wc,
               vecs[i].poke, vecs[i].exp_d, vecs[i].exp_e, vecs[i].exp_lat, $sformatf("vec%0d", i));
    end

    // Reset during the second beat of a half-word load aborts it silently.
    @(negedge clk);
    cur_sel = 0; size = 2'd1; sign_ext = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mem_ack = 1'b1; mem_rdata = 8'hAA;
    @(negedge clk);
    check("abort/second_beat_off", 64'(off_s), 64'h1);
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 8'hBB;
    @(negedge clk);
    reset = 1'b0; mem_ack = 1'b0;
    check("abort/mem_req", 64'(req_s), 64'h0);
    check("abort/mem_off", 64'(off_s), 64'h0);
    check("abort/busy", 64'(busy_s), 64'h0);
    check("abort/done", 64'(done_s), 64'h0);
    check("abort/err", 64'(err_s), 64'h0);
    check("abort/data_out", dout_s, 64'h0);
    @(negedge clk);
    check("abort/no_late_done", 64'(done_s), 64'h0);
    $display("abort reset mid-fetch done=%0b busy=%0b", done_s, busy_s);
    run_load(0, 2'd0, 1'b0, 64'hC3, 0, 0, 1'b0, 64'h0000_00C3, 1'b0, 2, "after_abort");

    for (int i = 0; i < 40; i++) begin
      int          s, sz, n, wb, wc, w;
      logic        sg, e;
      logic [63:0] b, exp;
      s  = $urandom_range(0, 1);
      sz = $urandom_range(0, 3);
      sg = 1'($urandom_range(0, 1));
      b  = {$urandom, $urandom};
      n  = 1 << sz;
      wb = $urandom_range(0, n - 1);
      wc = $urandom_range(0, 3);
      w  = (s == 1) ? 64 : 32;
      exp = model(w, sz, sg, b, e);
      run_load(s, 2'(sz), sg, b, wb, wc, 1'($urandom_range(0, 1)), exp, e,
               e ? 1 : (n + 1 + wc), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
